// File: rtl/cacheline_adaptor.sv
// Cache-line to memory-burst adaptor: turns one 256-bit line read/write into a
// fixed-length burst of 64-bit beats and returns a single-cycle completion pulse.

module cacheline_adaptor_checker (
    input logic clk,
    input logic rst_n,
    input logic read_o,
    input logic write_o,
    input logic resp_o
);

    // The memory port must never see a read and a write request together
    a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(read_o && write_o))
        else $error("read_o and write_o asserted together");

    // Completion is a one-cycle pulse; DONE always falls back to IDLE
    a_resp_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        resp_o |=> !resp_o)
        else $error("resp_o held longer than one cycle");

endmodule

module cacheline_adaptor #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int BURST_LEN  = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LINE_WIDTH-1:0] line_i,
    output logic [LINE_WIDTH-1:0] line_o,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic                  read_i,
    input  logic                  write_i,
    output logic                  resp_o,
    input  logic [BEAT_WIDTH-1:0] burst_i,
    output logic [BEAT_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic                  read_o,
    output logic                  write_o,
    input  logic                  resp_i
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [LINE_WIDTH-1:0]   line_r;
    logic [LINE_WIDTH-1:0]   line_o_r;
    logic [ADDR_WIDTH-1:0]   address_o_r;
    logic                    read_o_r;
    logic                    write_o_r;
    logic                    resp_o_r;
    logic [LINE_WIDTH-1:0]   line_nxt_s;
    logic [BEAT_WIDTH-1:0]   burst_o_s;
    logic                    last_beat_s;

    // Memory bursts always start on a line boundary
    function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] mask;
        mask = {ADDR_WIDTH{1'b1}} << OFF_W;
        return addr & mask;
    endfunction

    assign last_beat_s = (cnt_r == CNT_W'(BURST_LEN - 1));

    // Line buffer with the incoming read beat merged into slot cnt_r
    always_comb begin
        line_nxt_s = line_r;
        for (int b = 0; b < BURST_LEN; b++) begin
            line_nxt_s[b*BEAT_WIDTH +: BEAT_WIDTH] = (cnt_r == CNT_W'(b)) ?
                burst_i : line_r[b*BEAT_WIDTH +: BEAT_WIDTH];
        end
    end

    // Write beat follows cnt_r directly so an accept advances it the next cycle
    always_comb begin
        burst_o_s = {BEAT_WIDTH{1'b0}};
        for (int b = 0; b < BURST_LEN; b++) begin
            burst_o_s = burst_o_s |
                ({BEAT_WIDTH{write_o_r && (cnt_r == CNT_W'(b))}} &
                 line_r[b*BEAT_WIDTH +: BEAT_WIDTH]);
        end
    end

    // Transaction FSM with all request/response outputs held in registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            line_r      <= {LINE_WIDTH{1'b0}};
            line_o_r    <= {LINE_WIDTH{1'b0}};
            address_o_r <= {ADDR_WIDTH{1'b0}};
            read_o_r    <= 1'b0;
            write_o_r   <= 1'b0;
            resp_o_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    resp_o_r <= 1'b0;
                    cnt_r    <= {CNT_W{1'b0}};
                    // Writeback wins so a dirty victim leaves before the fill
                    if (write_i) begin
                        line_r      <= line_i;
                        address_o_r <= align_addr(address_i);
                        write_o_r   <= 1'b1;
                        state_r     <= WR;
                    end else if (read_i) begin
                        address_o_r <= align_addr(address_i);
                        read_o_r    <= 1'b1;
                        state_r     <= RD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD: begin
                    if (resp_i) begin
                        line_r <= line_nxt_s;
                        if (last_beat_s) begin
                            line_o_r    <= line_nxt_s;
                            cnt_r       <= {CNT_W{1'b0}};
                            read_o_r    <= 1'b0;
                            address_o_r <= {ADDR_WIDTH{1'b0}};
                            resp_o_r    <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                WR: begin
                    if (resp_i) begin
                        if (last_beat_s) begin
                            cnt_r       <= {CNT_W{1'b0}};
                            write_o_r   <= 1'b0;
                            address_o_r <= {ADDR_WIDTH{1'b0}};
                            resp_o_r    <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                DONE: begin
                    resp_o_r <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    address_o_r <= {ADDR_WIDTH{1'b0}};
                    read_o_r    <= 1'b0;
                    write_o_r   <= 1'b0;
                    resp_o_r    <= 1'b0;
                end
            endcase
        end
    end

    assign line_o    = line_o_r;
    assign resp_o    = resp_o_r;
    assign burst_o   = burst_o_s;
    assign address_o = address_o_r;
    assign read_o    = read_o_r;
    assign write_o   = write_o_r;

    cacheline_adaptor_checker u_checker (
        .clk     (clk),
        .rst_n   (rst_n),
        .read_o  (read_o_r),
        .write_o (write_o_r),
        .resp_o  (resp_o_r)
    );

endmodule
